// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the trace record packer.
//   - state_t        : capture FSM encodings (IDLE/ARMED/RUN/DONE)
//   - record layout  : bit offsets/widths of the 128-bit trace record
//   - MARKER_SEQ/TAG : field values identifying a drop-marker record
//   - pack_record()  : assembles a record from its fields
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned REC_W      = 128;
  localparam int unsigned INSN_LSB   = 0;
  localparam int unsigned INSN_W     = 32;
  localparam int unsigned PC_LSB     = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned TAG_LSB    = 64;
  localparam int unsigned TAG_W      = 8;
  localparam int unsigned SEQ_LSB    = 72;
  localparam int unsigned SEQ_W      = 24;
  localparam int unsigned TS_LSB     = 96;
  localparam int unsigned TS_FIELD_W = 32;

  localparam logic [SEQ_W-1:0] MARKER_SEQ = 24'hFFFFFF;
  localparam logic [TAG_W-1:0] MARKER_TAG = 8'hFF;

  function automatic logic [REC_W-1:0] pack_record(
    input logic [TS_FIELD_W-1:0] ts,
    input logic [SEQ_W-1:0]      seq,
    input logic [TAG_W-1:0]      tag,
    input logic [PC_W-1:0]       pc,
    input logic [INSN_W-1:0]     insn
  );
    logic [REC_W-1:0] rec;
    rec                          = '0;
    rec[TS_LSB   +: TS_FIELD_W]  = ts;
    rec[SEQ_LSB  +: SEQ_W]       = seq;
    rec[TAG_LSB  +: TAG_W]       = tag;
    rec[PC_LSB   +: PC_W]        = pc;
    rec[INSN_LSB +: INSN_W]      = insn;
    return rec;
  endfunction

endpackage

// File: rtl/trace_skid_fifo.sv
// trace_skid_fifo: single-clock synchronous FIFO holding 128-bit trace records.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data   : write request and record; ignored while full
//   i_pop            : read request; ignored while empty
//   o_full, o_empty  : status, both based on the pre-update occupancy
//   o_head           : record at the head (valid when !o_empty)
module trace_skid_fifo
  import trace_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [REC_W-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [REC_W-1:0] o_head
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rptr];
  // A push at full is refused even if a pop happens in the same cycle.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/trace_record_packer.sv
// trace_record_packer: write-side producer for fifo_ctrl. Samples trace
// events, gates them through an arm/trigger/limit FSM, stamps ts/seq,
// packs 128-bit records into a local skid FIFO and drains them to fifo_ctrl
// with at most one write every two cycles.
// Ports:
//   w_clk, rst        : clock, synchronous active-high reset
//   arm, stop         : session start / abort pulses (stop wins)
//   trig_en, trig_pc  : wait for a pc match before capturing
//   rec_limit         : records per session, 0 = unlimited
//   ev_valid/pc/insn/tag : trace event
//   fifo_full         : fifo_ctrl full flag
//   wr, data_in       : write strobe and record to fifo_ctrl
//   state, rec_cnt, drop_cnt : status
// Build option: define TRACE_DROP_MARKER_EN to insert a marker record
// (seq=MARKER_SEQ, tag=MARKER_TAG, insn=drop count) after drops.
module trace_record_packer
  import trace_pkg::*;
#(
  parameter int unsigned SKID_AW = 2,
  parameter int unsigned TS_W    = 32
) (
  input  logic         w_clk,
  input  logic         rst,
  input  logic         arm,
  input  logic         stop,
  input  logic         trig_en,
  input  logic [31:0]  trig_pc,
  input  logic [23:0]  rec_limit,
  input  logic         ev_valid,
  input  logic [31:0]  ev_pc,
  input  logic [31:0]  ev_insn,
  input  logic [7:0]   ev_tag,
  input  logic         fifo_full,
  output logic         wr,
  output logic [127:0] data_in,
  output logic [1:0]   state,
  output logic [23:0]  rec_cnt,
  output logic [15:0]  drop_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TS_W-1:0]  r_ts;
  logic [23:0]      r_seq;
  logic [23:0]      r_rec_cnt;
  logic [15:0]      r_drop_cnt;
  logic             r_wr;
  logic [127:0]     r_data;

  logic             w_trig_hit;
  logic             w_cap;
  logic             w_push_ev;
  logic             w_drop;
  logic             w_limit_hit;
  logic             w_arm_clr;
  logic [23:0]      w_rec_cnt_inc;
  logic [31:0]      w_ts32;
  logic [127:0]     w_ev_rec;
  logic             w_push;
  logic [127:0]     w_push_data;
  logic             w_pop;
  logic             w_skid_full;
  logic             w_skid_empty;
  logic [127:0]     w_skid_head;

  assign w_ts32        = 32'(r_ts);
  assign w_ev_rec      = pack_record(w_ts32, r_seq, ev_tag, ev_pc, ev_insn);

  // Capture happens in RUN, or in ARMED on the matching trigger event.
  assign w_trig_hit    = (r_state == ARMED) && trig_en && ev_valid && (ev_pc == trig_pc);
  assign w_cap         = ev_valid && !stop && ((r_state == RUN) || w_trig_hit);
  assign w_push_ev     = w_cap && !w_skid_full;
  assign w_drop        = w_cap && w_skid_full;
  assign w_rec_cnt_inc = r_rec_cnt + 24'd1;
  assign w_limit_hit   = w_push_ev && (rec_limit != '0) && (w_rec_cnt_inc == rec_limit);
  assign w_arm_clr     = arm && !stop && ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE, DONE: if (arm) w_state_nxt = ARMED;
        ARMED: begin
          if (!trig_en)        w_state_nxt = RUN;
          else if (w_trig_hit) w_state_nxt = w_limit_hit ? DONE : RUN;
        end
        RUN:   if (w_limit_hit) w_state_nxt = DONE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ts       <= '0;
      r_seq      <= '0;
      r_rec_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ts    <= r_ts + TS_W'(1);
      if (w_arm_clr) begin
        r_seq      <= '0;
        r_rec_cnt  <= '0;
        r_drop_cnt <= '0;
      end else begin
        if (w_push_ev) begin
          r_seq     <= r_seq + 24'd1;
          r_rec_cnt <= w_rec_cnt_inc;
        end
        if (w_drop && (r_drop_cnt != '1)) begin
          r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

`ifdef TRACE_DROP_MARKER_EN
  logic [15:0] r_mk_drops;
  logic        w_push_mk;

  // Marker waits for skid room; a real event push takes the slot first.
  assign w_push_mk = (r_mk_drops != '0) && !w_skid_full && !w_push_ev;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_mk_drops <= '0;
    end else if (w_push_mk) begin
      r_mk_drops <= '0;
    end else if (w_drop && (r_mk_drops != '1)) begin
      r_mk_drops <= r_mk_drops + 16'd1;
    end
  end

  assign w_push      = w_push_ev || w_push_mk;
  assign w_push_data = w_push_ev ? w_ev_rec
                     : pack_record(w_ts32, MARKER_SEQ, MARKER_TAG, 32'h0, {16'h0, r_mk_drops});
`else
  assign w_push      = w_push_ev;
  assign w_push_data = w_ev_rec;
`endif

  trace_skid_fifo #(
    .AW (SKID_AW)
  ) u_skid (
    .i_clk   (w_clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_skid_full),
    .o_empty (w_skid_empty),
    .o_head  (w_skid_head)
  );

  // fifo_ctrl samples wr one cycle before its full flag reflects it, so a
  // write is only issued when the previous cycle had none.
  assign w_pop = !w_skid_empty && !fifo_full && !r_wr;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_wr   <= 1'b0;
      r_data <= '0;
    end else begin
      r_wr <= w_pop;
      if (w_pop) r_data <= w_skid_head;
    end
  end

  assign wr       = r_wr;
  assign data_in  = r_data;
  assign state    = r_state;
  assign rec_cnt  = r_rec_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: doc/trace_record_packer.md
Name: trace_record_packer

Overview:
- Write-side producer that feeds fifo_ctrl. It samples per-instruction trace events (pc, insn, tag) from the core on w_clk.
- Events are gated by an arm/trigger/limit state machine, stamped with a timestamp and sequence number, and packed into 128-bit records.
- Records drain through a small local skid FIFO into fifo_ctrl's wr/data_in/o_full_flag interface.
- It absorbs bursts, counts drops, and never relies on fifo_ctrl silently discarding writes.

Parameters:
- SKID_AW, 2, log2 depth of the local skid FIFO (default 4 entries).
- TS_W, 32, timestamp counter width; must be ≤ 32, zero-extended into the ts field.

Ports:
- w_clk  input  1  clock (same clock as fifo_ctrl write side)
- rst  input  1  synchronous active-high reset
- arm  input  1  pulse: start a new capture session
- stop  input  1  pulse: abort capture, return to IDLE
- trig_en  input  1  1 = wait for a pc match before capturing
- trig_pc  input  32  trigger pc value
- rec_limit  input  24  records per session; 0 = unlimited
- ev_valid  input  1  event strobe, at most one per cycle
- ev_pc  input  32  event pc
- ev_insn  input  32  event instruction word
- ev_tag  input  8  event flags/tag
- fifo_full  input  1  from fifo_ctrl o_full_flag
- wr  output  1  write strobe to fifo_ctrl
- data_in  output  128  record to fifo_ctrl
- state  output  2  current FSM state
- rec_cnt  output  24  records accepted this session
- drop_cnt  output  16  events dropped this session, saturating

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, wr=0, data_in=0, rec_cnt=0, drop_cnt=0, seq=0, ts=0, skid emptied.
- Record layout: [127:96] ts, [95:72] seq, [71:64] tag, [63:32] pc, [31:0] insn. fifo_ctrl emits word 0 (insn) first.
- ts: free-running counter, +1 every cycle from reset, wraps. An event's ts is its ev_valid cycle.
- FSM states: IDLE=0, ARMED=1, RUN=2, DONE=3.
  - IDLE -arm-> ARMED. Clears seq, rec_cnt, drop_cnt.
  - DONE -arm-> ARMED. Same clears.
  - ARMED with trig_en=0 -> RUN on the next cycle.
  - ARMED with trig_en=1 -> RUN on ev_valid && ev_pc==trig_pc. The matching event is captured.
  - RUN -> DONE in the cycle rec_cnt becomes rec_limit (rec_limit≠0).
  - Any state -stop-> IDLE.
  - stop and arm in the same cycle: stop wins.
  - arm in ARMED or RUN is ignored.
- Capture (RUN, or the trigger cycle): ev_valid pushes a record into the skid FIFO if it is not full. Then seq+1 (wraps at 24 bits) and rec_cnt+1.
- Drop: ev_valid while skid full -> record dropped. drop_cnt+1, saturating at 16'hFFFF. seq and rec_cnt unchanged.
- Events outside RUN/trigger are ignored and not counted.
- Drain: the skid head pops into data_in with wr=1 when all three hold:
  - skid is non-empty;
  - fifo_full==0 this cycle;
  - wr was 0 in the previous cycle.
- Why wr never asserts on consecutive cycles: fifo_ctrl registers wr/data_in one cycle before gating with full. Spacing writes 2 cycles guarantees fifo_full reflects every prior write, so no record is lost downstream. Max drain rate is one record per 2 cycles.
- data_in holds its value when wr=0. wr is a 1-cycle pulse.
- Skid drain continues in IDLE/DONE until empty; stop does not flush.
- Simultaneous push and pop on the skid are allowed. At full with a same-cycle pop, the push is still refused (push checks pre-pop full).
- Reset mid-operation: the skid is discarded. A wr issued the cycle before rst still lands in fifo_ctrl; fifo_ctrl is reset by the same rst.

Optional Feature:
- TRACE_DROP_MARKER_EN defined:
  - After one or more drops, the first cycle with skid room and no ev_valid push inserts a marker record: ts, seq=24'hFFFFFF, tag=8'hFF, pc=0, insn={16'h0, drops since last marker}.
  - The drops-since-marker counter (saturating at 16 bits) then clears.
  - Markers do not advance seq or rec_cnt.
  - A real event push has priority over a marker.
- Undefined: drops are visible only via drop_cnt; no marker logic is synthesized.

Decomposition:
- Package trace_pkg:
  - state encodings IDLE/ARMED/RUN/DONE;
  - record field bit offsets/widths;
  - MARKER_SEQ=24'hFFFFFF and MARKER_TAG=8'hFF;
  - a record-pack function.
- Sub-module trace_skid_fifo: single-clock synchronous FIFO, parameter AW and 128-bit width, push/pop/full/empty/head outputs, synchronous reset.

Test Plan:
- Trigger: arm, trig_en=1, trig_pc=0x100; events pc 0xF0,0x100,0x104 -> first pushed record pc=0x100 seq=0, then 0x104 seq=1; rec_cnt=2.
- Limit: trig_en=0, rec_limit=3, 5 back-to-back events -> exactly 3 records written, state=DONE; later events ignored; drop_cnt=0.
- Backpressure: hold fifo_full=1, 6 events in RUN, default depth 4 -> 4 buffered, drop_cnt=2; release full -> 4 wr pulses on alternating cycles, seq 0..3.
- Write spacing: stream events every cycle with fifo_full=0 -> wr never high on two consecutive cycles; every record matches the model in order.
- Drop marker (with TRACE_DROP_MARKER_EN): as in the backpressure case -> fifth record written is marker with insn=0x0000_0002, tag=0xFF, seq=0xFFFFFF.
- Reset/stop: stop and arm in the same cycle during RUN -> IDLE. rst with 3 records buffered -> wr=0 next cycle, skid empty, all counters 0.
